// File: rtl/counter_sequence_checker.sv
// counter_sequence_checker
// Monitors a counter's output bus and checks that each qualified sample follows
// the expected down (or up) sequence, modulo 2^WIDTH. Locks after a run of
// legal transitions, pulses err on a break while locked, pulses wrap on a legal
// wrap-around while locked, and keeps saturating counts of both.
module counter_sequence_checker #(
   parameter int WIDTH        = 3,
   parameter int LOCK_MATCHES = 2,
   parameter int ERR_W        = 4,
   parameter int WRAP_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  q_in,
   input  logic              valid,
   input  logic              dir,
   output logic              locked,
   output logic              err,
   output logic              wrap,
   output logic [ERR_W-1:0]  err_count,
   output logic [WRAP_W-1:0] wrap_count,
   output logic [WIDTH-1:0]  expected
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SYNC     = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAX_VAL   = '1;
   localparam logic [2:0]       LOCK_TGT  = 3'(LOCK_MATCHES);

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    ref_q, ref_d;
   logic [2:0]          match_q, match_d;
   logic                dir_q, dir_d;
   logic                err_q, err_d;
   logic                wrap_q, wrap_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;

   logic [WIDTH-1:0]    exp_val;
   logic [2:0]          match_inc;
   logic                legal;
   logic                dir_chg;
   logic                wrap_edge;

   // Value the next sample must carry, plus the per-sample classification.
   always_comb begin
      exp_val   = dir_q ? (ref_q + WIDTH'(1)) : (ref_q - WIDTH'(1));
      match_inc = match_q + 3'd1;
      legal     = (q_in == exp_val);
      dir_chg   = (dir != dir_q);
      wrap_edge = dir_q ? ((ref_q == MAX_VAL) && (q_in == '0))
                        : ((ref_q == '0) && (q_in == MAX_VAL));
   end

   // Next-state and pulse logic; every valid sample becomes the new reference.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      ref_d      = ref_q;
      match_d    = match_q;
      dir_d      = dir_q;
      err_d      = 1'b0;
      wrap_d     = 1'b0;
      err_cnt_d  = err_cnt_q;
      wrap_cnt_d = wrap_cnt_q;

      if (valid) begin
         ref_d = q_in;
         dir_d = dir;
         unique case (state_q)
            ST_UNLOCKED: begin
               match_d = 3'd0;
               state_d = ST_SYNC;
            end
            ST_SYNC: begin
               if (dir_chg || !legal) begin
                  match_d = 3'd0;
               end else begin
                  match_d = match_inc;
                  if (match_inc == LOCK_TGT) state_d = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (dir_chg) begin
                  // A direction change is a fresh reference, not a break.
                  match_d = 3'd0;
                  state_d = ST_SYNC;
               end else if (!legal) begin
                  err_d   = 1'b1;
                  match_d = 3'd0;
                  state_d = ST_SYNC;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
               end else if (wrap_edge) begin
                  wrap_d = 1'b1;
                  if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
               end
            end
            default: begin
               match_d = 3'd0;
               state_d = ST_UNLOCKED;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge here, so it lives inside the clocked branch, not the sensitivity list.
      if (!rst_n) begin
         state_q    <= ST_UNLOCKED;
         ref_q      <= '0;
         match_q    <= 3'd0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         wrap_q     <= 1'b0;
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         ref_q      <= ref_d;
         match_q    <= match_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         wrap_q     <= wrap_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign err        = err_q;
   assign wrap       = wrap_q;
   assign err_count  = err_cnt_q;
   assign wrap_count = wrap_cnt_q;
   assign expected   = (state_q == ST_UNLOCKED) ? '0 : exp_val;

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Bench for counter_sequence_checker: directed vectors, a run-length model of
// the sequence rules checked every cycle, and literal expectations that pin it.
module tb_counter_sequence_checker;

   localparam int WIDTH        = 3;
   localparam int LOCK_MATCHES = 2;
   localparam int ERR_W        = 4;
   localparam int WRAP_W       = 8;
   localparam int MAXV         = (1 << WIDTH) - 1;

   logic              clk;
   logic              rst_n;
   logic [WIDTH-1:0]  q_in;
   logic              valid;
   logic              dir;
   logic              locked;
   logic              err;
   logic              wrap;
   logic [ERR_W-1:0]  err_count;
   logic [WRAP_W-1:0] wrap_count;
   logic [WIDTH-1:0]  expected;

   counter_sequence_checker #(
      .WIDTH(WIDTH), .LOCK_MATCHES(LOCK_MATCHES), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .valid(valid), .dir(dir),
      .locked(locked), .err(err), .wrap(wrap), .err_count(err_count),
      .wrap_count(wrap_count), .expected(expected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model: last sample, its direction, and the length of the current legal run.
   bit m_have;
   int m_prev;
   int m_dir;
   int m_run;
   bit m_err;
   bit m_wrap;
   int m_errc;
   int m_wrapc;

   function automatic int m_locked();
      return (m_have && m_run >= LOCK_MATCHES) ? 1 : 0;
   endfunction

   function automatic int m_expected();
      if (!m_have) return 0;
      return (m_prev + (m_dir != 0 ? 1 : MAXV)) % (MAXV + 1);
   endfunction

   task automatic model_update(input bit r, input bit v, input int d, input int q);
      int  was_locked;
      int  ex;
      bit  same_dir;
      bit  lgl;
      if (!r) begin
         m_have = 0; m_prev = 0; m_dir = 0; m_run = 0;
         m_err = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
      end else if (!v) begin
         m_err = 0; m_wrap = 0;
      end else begin
         was_locked = m_locked();
         ex         = m_expected();
         same_dir   = m_have && (d == m_dir);
         lgl        = same_dir && (q == ex);
         m_err      = (was_locked != 0) && same_dir && (q != ex);
         m_wrap     = (was_locked != 0) && lgl &&
                      ((d == 0 && m_prev == 0 && q == MAXV) ||
                       (d == 1 && m_prev == MAXV && q == 0));
         m_run      = lgl ? m_run + 1 : 0;
         if (m_err  && m_errc  < (1 << ERR_W) - 1)  m_errc++;
         if (m_wrap && m_wrapc < (1 << WRAP_W) - 1) m_wrapc++;
         m_prev = q; m_dir = d; m_have = 1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; returns at the following falling edge.
   task automatic step(input bit r, input bit v, input bit d, input int q);
      rst_n = r; valid = v; dir = d; q_in = WIDTH'(q);
      @(posedge clk);
      model_update(r, v, int'(d), q);
      @(negedge clk);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("locked",     locked,     m_locked());
         check("err",        err,        m_err);
         check("wrap",       wrap,       m_wrap);
         check("err_count",  err_count,  m_errc);
         check("wrap_count", wrap_count, m_wrapc);
         check("expected",   expected,   m_expected());
         check("err_and_wrap_exclusive", err & wrap, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cur;
      int a;
      int b;
      rst_n = 1'b0; valid = 1'b0; dir = 1'b0; q_in = '0;
      @(negedge clk);

      // Reset for two edges with valid high.
      step(0, 1, 0, 5);
      chk_en = 1'b1;
      step(0, 1, 0, 3);
      check("reset_locked", locked, 0);
      check("reset_err_count", err_count, 0);
      check("reset_expected", expected, 0);

      // Lock on down sequence: 0 is the reference, 7 and 6 are the matches.
      step(1, 1, 0, 0);
      check("lock_after_ref", locked, 0);
      step(1, 1, 0, 7);
      check("expected_after_7", expected, 6);
      check("not_locked_after_7", locked, 0);
      step(1, 1, 0, 6);
      check("locked_after_6", locked, 1);
      for (int v = 5; v >= 1; v--) step(1, 1, 0, v);

      // Sixteen full periods; each 0->7 edge while locked counts a wrap.
      for (int p = 0; p < 16; p++)
         for (int k = 0; k < 8; k++) step(1, 1, 0, (8 - k) % 8);
      check("wrap_count_16", wrap_count, 16);
      check("no_err_in_down_run", err_count, 0);

      // Break detection at ref = 5.
      step(1, 1, 0, 0);
      step(1, 1, 0, 7);
      step(1, 1, 0, 6);
      step(1, 1, 0, 5);
      check("locked_at_5", locked, 1);
      step(1, 1, 0, 2);
      check("break_err", err, 1);
      check("break_err_count", err_count, 1);
      check("break_unlock", locked, 0);
      step(1, 1, 0, 1);
      check("break_err_one_cycle", err, 0);
      step(1, 1, 0, 0);
      check("relock_after_0", locked, 1);
      check("relock_err_count", err_count, 1);

      // Stall: valid low, q_in wandering; outputs hold.
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 0, int'($urandom_range(0, MAXV)));
         check("stall_locked", locked, 1);
         check("stall_expected", expected, 7);
      end
      step(1, 1, 0, 7);
      check("resume_no_err", err, 0);
      check("resume_wrap", wrap, 1);
      check("resume_wrap_count", wrap_count, 18);

      // Up direction: direction change drops lock without err.
      step(1, 1, 1, 6);
      check("dirchg_unlock", locked, 0);
      check("dirchg_no_err", err, 0);
      step(1, 1, 1, 7);
      step(1, 1, 1, 0);
      check("up_locked_after_0", locked, 1);
      for (int v = 1; v <= 7; v++) step(1, 1, 1, v);
      step(1, 1, 1, 0);
      check("up_wrap", wrap, 1);
      check("up_wrap_count", wrap_count, 19);
      step(1, 1, 0, 0);
      check("down_switch_unlock", locked, 0);
      check("down_switch_no_err", err, 0);
      check("down_switch_expected", expected, 7);

      // Saturation: twenty breaks, each after a relock.
      cur = 0;
      for (int n = 0; n < 20; n++) begin
         a = (cur + MAXV) % (MAXV + 1);
         b = (a + MAXV) % (MAXV + 1);
         step(1, 1, 0, a);
         step(1, 1, 0, b);
         step(1, 1, 0, b);
         check("sat_err_pulse", err, 1);
         cur = b;
      end
      check("err_count_saturated", err_count, 15);

      // Reset mid-LOCKED.
      a = (cur + MAXV) % (MAXV + 1);
      b = (a + MAXV) % (MAXV + 1);
      step(1, 1, 0, a);
      step(1, 1, 0, b);
      check("locked_before_reset", locked, 1);
      step(0, 1, 0, (b + MAXV) % (MAXV + 1));
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
      check("rst_wrap", wrap, 0);
      check("rst_err_count", err_count, 0);
      check("rst_wrap_count", wrap_count, 0);
      check("rst_expected", expected, 0);

      // Reacquire after reset.
      step(1, 1, 0, 3);
      step(1, 1, 0, 2);
      step(1, 1, 0, 1);
      check("reacquire_locked", locked, 1);
      check("reacquire_expected", expected, 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
